regfile_sb: RTL

Parametrised multi-read, dual-write register file with a per-register pending-load scoreboard. It replaces the single-write, level-sensitive register file in the RISC-V core.
- Port A takes ALU/writeback results.
- Port B takes load-return data.
- The scoreboard tracks registers whose load is outstanding, so decode can stall on RAW hazards.
- All state updates on the rising edge of clk.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_scoreboard.sv | 64 ++++++
 rtl/regfile_sb.sv | 118 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the regfile_sb register file.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;

    // Architectural zero register: hard-wired to 0, never pending.
    localparam int REG_ZERO  = 0;

    typedef logic [NREGS_DEF-1:0] sb_vec_t;

    // Low bit of the given port's slice within a packed multi-port bus.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: one busy bit per register plus reserve-error detection.
// Reserve (set) has priority over load-return (clear) on the same register.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int  NREGS = NREGS_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    output logic [NREGS-1:0] busy_vec,
    output logic             rsv_err
);

    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_next_s;
    logic             rsv_err_r;
    logic             rsv_err_next_s;
    logic             rsv_hit_clr_s;

    // Busy next-state: reserve wins over a simultaneous clear (a new load was issued).
    always_comb begin
        busy_next_s = busy_r;
        for (int r = 0; r < NREGS; r++) begin
            if (rsv_en && (rsv_addr == AW'(r))) begin
                busy_next_s[r] = 1'b1;
            end else if (wb_en && (wb_addr == AW'(r))) begin
                busy_next_s[r] = 1'b0;
            end else begin
                busy_next_s[r] = busy_r[r];
            end
        end
        busy_next_s[REG_ZERO] = 1'b0;
    end

    // Error when re-reserving a register whose load is still outstanding.
    always_comb begin
        rsv_hit_clr_s = wb_en && (wb_addr == rsv_addr);
        if (rsv_en && busy_r[rsv_addr] && !rsv_hit_clr_s) begin
            rsv_err_next_s = 1'b1;
        end else begin
            rsv_err_next_s = 1'b0;
        end
    end

    // Scoreboard state and error pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r    <= '0;
            rsv_err_r <= 1'b0;
        end else begin
            busy_r    <= busy_next_s;
            rsv_err_r <= rsv_err_next_s;
        end
    end

    assign busy_vec = busy_r;
    assign rsv_err  = rsv_err_r;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with pending-load scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes onto the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int  XLEN  = XLEN_DEF,
    parameter int  NREGS = NREGS_DEF,
    parameter int  NRD   = NRD_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wa_en,
    input  logic [AW-1:0]       wa_addr,
    input  logic [XLEN-1:0]     wa_data,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic [NREGS-1:0]    busy_vec,
    output logic                wr_conflict,
    output logic                rsv_err
);

    logic [XLEN-1:0] regs_r [NREGS];
    logic            wa_ok_s;
    logic            wb_ok_s;
    logic            conflict_s;
    logic            wr_conflict_r;

    regfile_scoreboard #(
        .NREGS(NREGS)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .busy_vec (busy_vec),
        .rsv_err  (rsv_err)
    );

    // Qualify writes: address 0 is dropped, collisions flag a conflict.
    always_comb begin
        wa_ok_s = wa_en && (wa_addr != AW'(REG_ZERO));
        wb_ok_s = wb_en && (wb_addr != AW'(REG_ZERO));
        if (wa_ok_s && wb_ok_s && (wa_addr == wb_addr)) begin
            conflict_s = 1'b1;
        end else begin
            conflict_s = 1'b0;
        end
    end

    // Storage update; port A is applied last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_r[r] <= '0;
            end
            wr_conflict_r <= 1'b0;
        end else begin
            if (wb_ok_s) begin
                regs_r[wb_addr] <= wb_data;
            end
            if (wa_ok_s) begin
                regs_r[wa_addr] <= wa_data;
            end
            wr_conflict_r <= conflict_s;
        end
    end

    assign wr_conflict = wr_conflict_r;

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0]   addr_s;
        logic [XLEN-1:0] data_s;
        logic            busy_s;

        assign addr_s = rd_addr[slice_lo(g, AW) +: AW];

        // Read data mux; register 0 is forced to zero regardless of storage.
        always_comb begin
            if (addr_s == AW'(REG_ZERO)) begin
                data_s = '0;
`ifdef REGFILE_BYPASS_EN
            end else if (wa_en && (wa_addr == addr_s)) begin
                data_s = wa_data;
            end else if (wb_en && (wb_addr == addr_s)) begin
                data_s = wb_data;
`endif
            end else begin
                data_s = regs_r[addr_s];
            end
        end

        // Busy lookup; with forwarding, a returning load hides the pending bit.
        always_comb begin
`ifdef REGFILE_BYPASS_EN
            if (wb_en && (wb_addr == addr_s) && !(rsv_en && (rsv_addr == addr_s))) begin
                busy_s = 1'b0;
            end else begin
                busy_s = busy_vec[addr_s];
            end
`else
            busy_s = busy_vec[addr_s];
`endif
        end

        assign rd_data[slice_lo(g, XLEN) +: XLEN] = data_s;
        assign rd_busy[g]                         = busy_s;
    end

endmodule
